// File: rtl/y86_regfile.sv
// y86_regfile
// Register file for the Y86-64 datapath. It sits between decode (two
// combinational read ports) and write-back (two clocked write ports).
//
// Parameters
//   WIDTH   bits per register
//   NREGS   implemented registers, IDs 0..NREGS-1
//   ADDR_W  register-ID width
//   NONE_ID ID meaning "no register"; never read or written
//   BYPASS  1 = same-cycle write data is forwarded to the read ports
//
// Ports
//   clk         rising-edge clock for all state
//   reset       synchronous, active-high; clears every register
//   en          global write enable (0 = stall, no writes)
//   srcA, srcB  read register IDs
//   valA, valB  read data (0 for an invalid ID)
//   dstE, valE  write port E (execute stage)
//   dstM, valM  write port M (memory stage); wins over E on the same ID
module y86_regfile #(
   parameter int                WIDTH   = 64,
   parameter int                NREGS   = 15,
   parameter int                ADDR_W  = 4,
   parameter logic [ADDR_W-1:0] NONE_ID = ADDR_W'(4'hF),
   parameter bit                BYPASS  = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic [ADDR_W-1:0] srcA,
   input  logic [ADDR_W-1:0] srcB,
   output logic [WIDTH-1:0]  valA,
   output logic [WIDTH-1:0]  valB,
   input  logic [ADDR_W-1:0] dstE,
   input  logic [WIDTH-1:0]  valE,
   input  logic [ADDR_W-1:0] dstM,
   input  logic [WIDTH-1:0]  valM
);

   logic [WIDTH-1:0] regs [NREGS];

   logic [NREGS-1:0] hit_e;
   logic [NREGS-1:0] hit_m;
   logic [WIDTH-1:0] rd_a;
   logic [WIDTH-1:0] rd_b;

   // An ID is usable only if it names an implemented register and is not
   // the "no register" code (which may itself lie inside 0..NREGS-1).
   function automatic logic id_valid(input logic [ADDR_W-1:0] id);
      return (32'(id) < 32'(NREGS)) && (id != NONE_ID);
   endfunction

   // Per-register write decode. Decoding against each index keeps every
   // array access in range even when an ID is >= NREGS.
   always_comb begin
      hit_e = '0;
      hit_m = '0;
      for (int i = 0; i < NREGS; i++) begin
         hit_e[i] = id_valid(dstE) && (dstE == ADDR_W'(i));
         hit_m[i] = id_valid(dstM) && (dstM == ADDR_W'(i));
      end
   end

   // Port M is checked first so that a dstE == dstM collision keeps valM
   // (popq %rsp: the popped value overrides the stack-pointer update).
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (en) begin
         for (int i = 0; i < NREGS; i++) begin
            if (hit_m[i]) begin
               regs[i] <= valM;
            end else if (hit_e[i]) begin
               regs[i] <= valE;
            end
         end
      end
   end

   // Stored-value read mux; invalid IDs read as zero.
   always_comb begin
      rd_a = '0;
      rd_b = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (id_valid(srcA) && (srcA == ADDR_W'(i))) begin
            rd_a = regs[i];
         end
         if (id_valid(srcB) && (srcB == ADDR_W'(i))) begin
            rd_b = regs[i];
         end
      end
   end

   generate
      if (BYPASS) begin : g_bypass
         // Forward only what the coming edge will actually commit: nothing
         // during reset or stall, and M ahead of E as in the write path.
         logic fwd_ok;
         assign fwd_ok = !reset && en;

         always_comb begin
            valA = rd_a;
            if (fwd_ok && id_valid(srcA)) begin
               if (id_valid(dstM) && (srcA == dstM)) begin
                  valA = valM;
               end else if (id_valid(dstE) && (srcA == dstE)) begin
                  valA = valE;
               end
            end
         end

         always_comb begin
            valB = rd_b;
            if (fwd_ok && id_valid(srcB)) begin
               if (id_valid(dstM) && (srcB == dstM)) begin
                  valB = valM;
               end else if (id_valid(dstE) && (srcB == dstE)) begin
                  valB = valE;
               end
            end
         end
      end else begin : g_no_bypass
         assign valA = rd_a;
         assign valB = rd_b;
      end
   endgenerate

endmodule

// File: tb/tb_y86_regfile.sv
module tb_y86_regfile;

   localparam logic [3:0] NONE = 4'hF;

   logic        clk;
   logic        reset;
   logic        en;
   logic [3:0]  srcA, srcB, dstE, dstM;
   logic [63:0] valE, valM;
   logic [63:0] valA0, valB0, valA1, valB1, valA2, valB2;

   logic [63:0] exp_r [15];
   int          checks;
   int          errors;

   // dut0: default build; dut1: write-through bypass; dut2: only 8 registers
   y86_regfile #(.BYPASS(1'b0)) dut0 (
      .clk(clk), .reset(reset), .en(en),
      .srcA(srcA), .srcB(srcB), .valA(valA0), .valB(valB0),
      .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM)
   );

   y86_regfile #(.BYPASS(1'b1)) dut1 (
      .clk(clk), .reset(reset), .en(en),
      .srcA(srcA), .srcB(srcB), .valA(valA1), .valB(valB1),
      .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM)
   );

   y86_regfile #(.NREGS(8)) dut2 (
      .clk(clk), .reset(reset), .en(en),
      .srcA(srcA), .srcB(srcB), .valA(valA2), .valB(valB2),
      .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en   = 1'b0;
      dstE = NONE;
      dstM = NONE;
      valE = '0;
      valM = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      srcA = 4'd0;
      srcB = NONE;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (valA0 !== 64'h0) begin
         errors++;
         $display("FAIL reset_first_read: got %h expected %h", valA0, 64'h0);
      end
      for (int i = 0; i < 15; i++) begin
         en   = 1'b1;
         dstE = 4'(i);
         valE = 64'hDEAD_BEEF;
         tick();
      end
      idle();
      srcA = 4'd14;
      srcB = 4'd0;
      #1;
      checks++;
      if (valA0 !== 64'hDEAD_BEEF || valB0 !== 64'hDEAD_BEEF) begin
         errors++;
         $display("FAIL preload: got %h/%h expected %h", valA0, valB0, 64'hDEAD_BEEF);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 15; i++) begin
         srcA = 4'(i);
         srcB = 4'(14 - i);
         #1;
         checks++;
         if (valA0 !== 64'h0 || valB0 !== 64'h0 || valA1 !== 64'h0 || valB1 !== 64'h0) begin
            errors++;
            $display("FAIL reset_clear id %0d: got %h/%h/%h/%h expected 0",
                     i, valA0, valB0, valA1, valB1);
         end
      end
      srcA = NONE;
      #1;
      checks++;
      if (valA0 !== 64'h0) begin
         errors++;
         $display("FAIL reset_none_read: got %h expected 0", valA0);
      end
      for (int i = 0; i < 15; i++) exp_r[i] = '0;
   endtask

   task automatic test_dual_write();
      en   = 1'b1;
      dstE = 4'd3;
      valE = 64'h11;
      dstM = 4'd7;
      valM = 64'h22;
      tick();
      idle();
      exp_r[3] = 64'h11;
      exp_r[7] = 64'h22;
      srcA = 4'd3;
      srcB = 4'd7;
      #1;
      checks++;
      if (valA0 !== 64'h11 || valB0 !== 64'h22) begin
         errors++;
         $display("FAIL dual_write: got %h/%h expected 11/22", valA0, valB0);
      end
      for (int i = 0; i < 15; i++) begin
         srcA = 4'(i);
         #1;
         checks++;
         if (valA0 !== exp_r[i]) begin
            errors++;
            $display("FAIL dual_write_others id %0d: got %h expected %h", i, valA0, exp_r[i]);
         end
      end
   endtask

   task automatic test_collision();
      en   = 1'b1;
      dstE = 4'd4;
      valE = 64'hAAAA;
      dstM = 4'd4;
      valM = 64'h5555;
      tick();
      idle();
      exp_r[4] = 64'h5555;
      srcA = 4'd4;
      srcB = 4'd4;
      #1;
      checks++;
      if (valA0 !== 64'h5555 || valB0 !== 64'h5555 || valA1 !== 64'h5555) begin
         errors++;
         $display("FAIL collision: got %h/%h/%h expected 5555", valA0, valB0, valA1);
      end
   endtask

   task automatic test_stall_none();
      en   = 1'b1;
      dstE = 4'd2;
      valE = 64'h5;
      tick();
      exp_r[2] = 64'h5;
      en   = 1'b0;
      valE = 64'h99;
      dstM = 4'd2;
      valM = 64'h98;
      tick();
      idle();
      srcA = 4'd2;
      #1;
      checks++;
      if (valA0 !== 64'h5) begin
         errors++;
         $display("FAIL stall_hold: got %h expected %h", valA0, 64'h5);
      end
      en   = 1'b1;
      dstE = NONE;
      valE = 64'h77;
      dstM = NONE;
      valM = 64'h88;
      tick();
      idle();
      for (int i = 0; i < 15; i++) begin
         srcA = 4'(i);
         #1;
         checks++;
         if (valA0 !== exp_r[i]) begin
            errors++;
            $display("FAIL none_write id %0d: got %h expected %h", i, valA0, exp_r[i]);
         end
      end
      srcA = NONE;
      #1;
      checks++;
      if (valA0 !== 64'h0) begin
         errors++;
         $display("FAIL none_read: got %h expected 0", valA0);
      end
   endtask

   task automatic test_high_id();
      en   = 1'b1;
      dstE = 4'd9;
      valE = 64'h1234;
      dstM = 4'd14;
      valM = 64'h4321;
      tick();
      idle();
      exp_r[9]  = 64'h1234;
      exp_r[14] = 64'h4321;
      srcA = 4'd9;
      srcB = 4'd14;
      #1;
      checks++;
      if (valA0 !== 64'h1234 || valB0 !== 64'h4321) begin
         errors++;
         $display("FAIL high_id_full: got %h/%h expected 1234/4321", valA0, valB0);
      end
      checks++;
      if (valA2 !== 64'h0 || valB2 !== 64'h0) begin
         errors++;
         $display("FAIL high_id_small: got %h/%h expected 0/0", valA2, valB2);
      end
      for (int i = 0; i < 8; i++) begin
         srcA = 4'(i);
         #1;
         checks++;
         if (valA2 !== exp_r[i]) begin
            errors++;
            $display("FAIL high_id_small_others id %0d: got %h expected %h", i, valA2, exp_r[i]);
         end
      end
   endtask

   task automatic test_bypass();
      en   = 1'b1;
      dstE = 4'd5;
      valE = 64'h1;
      tick();
      exp_r[5] = 64'h1;
      valE = 64'h2;
      srcA = 4'd5;
      srcB = 4'd5;
      #1;
      checks++;
      if (valA1 !== 64'h2 || valA0 !== 64'h1) begin
         errors++;
         $display("FAIL bypass_e: got byp %h nobyp %h expected 2/1", valA1, valA0);
      end
      dstM = 4'd5;
      valM = 64'h3;
      #1;
      checks++;
      if (valA1 !== 64'h3 || valB1 !== 64'h3 || valB0 !== 64'h1) begin
         errors++;
         $display("FAIL bypass_m: got %h/%h nobyp %h expected 3/3/1", valA1, valB1, valB0);
      end
      dstE = 4'd4;
      dstM = NONE;
      #1;
      checks++;
      if (valA1 !== 64'h1) begin
         errors++;
         $display("FAIL bypass_nomatch: got %h expected 1", valA1);
      end
      dstE = 4'd5;
      en   = 1'b0;
      #1;
      checks++;
      if (valA1 !== 64'h1) begin
         errors++;
         $display("FAIL bypass_stall: got %h expected 1", valA1);
      end
      en    = 1'b1;
      reset = 1'b1;
      #1;
      checks++;
      if (valA1 !== 64'h1) begin
         errors++;
         $display("FAIL bypass_reset: got %h expected 1", valA1);
      end
      reset = 1'b0;
      dstE  = NONE;
      srcA  = NONE;
      #1;
      checks++;
      if (valA1 !== 64'h0) begin
         errors++;
         $display("FAIL bypass_none: got %h expected 0", valA1);
      end
      idle();
      tick();
   endtask

   task automatic test_reset_vs_write();
      reset = 1'b1;
      en    = 1'b1;
      dstE  = 4'd1;
      valE  = 64'hFF;
      srcA  = 4'd1;
      srcB  = 4'd5;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 15; i++) exp_r[i] = '0;
      checks++;
      if (valA0 !== 64'h0 || valB0 !== 64'h0) begin
         errors++;
         $display("FAIL reset_drops_write: got %h/%h expected 0/0", valA0, valB0);
      end
      tick();
      idle();
      exp_r[1] = 64'hFF;
      #1;
      checks++;
      if (valA0 !== 64'hFF) begin
         errors++;
         $display("FAIL write_after_reset: got %h expected ff", valA0);
      end
   endtask

   task automatic test_reset_between_edges();
      srcA  = 4'd1;
      reset = 1'b1;
      #2;
      checks++;
      if (valA0 !== 64'hFF) begin
         errors++;
         $display("FAIL reset_async_leak: got %h expected ff", valA0);
      end
      tick();
      reset = 1'b0;
      exp_r[1] = '0;
      checks++;
      if (valA0 !== 64'h0) begin
         errors++;
         $display("FAIL reset_on_edge: got %h expected 0", valA0);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 6; k++) begin
         en   = 1'b1;
         dstE = 4'(k);
         valE = 64'(100 + k);
         dstM = 4'(k + 6);
         valM = 64'(200 + k);
         srcA = 4'(k);
         srcB = 4'(k + 6);
         #1;
         checks++;
         if (valA0 !== exp_r[k] || valB0 !== exp_r[k + 6]) begin
            errors++;
            $display("FAIL b2b_before k %0d: got %h/%h expected %h/%h",
                     k, valA0, valB0, exp_r[k], exp_r[k + 6]);
         end
         tick();
         exp_r[k]     = 64'(100 + k);
         exp_r[k + 6] = 64'(200 + k);
         checks++;
         if (valA0 !== exp_r[k] || valB0 !== exp_r[k + 6]) begin
            errors++;
            $display("FAIL b2b_after k %0d: got %h/%h expected %h/%h",
                     k, valA0, valB0, exp_r[k], exp_r[k + 6]);
         end
      end
      idle();
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      srcA   = '0;
      srcB   = '0;
      idle();
      for (int i = 0; i < 15; i++) exp_r[i] = '0;
      test_reset();
      test_dual_write();
      test_collision();
      test_stall_none();
      test_high_id();
      test_bypass();
      test_reset_vs_write();
      test_reset_between_edges();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/y86_regfile.md
# y86_regfile

Parametrised register file for the Y86-64 datapath: an array of enable-gated, synchronously-reset storage words with two combinational read ports (srcA/srcB) and two clocked write ports (E from execute, M from memory). It sits between decode (reads) and write-back (writes). It generalises the single enable/reset flip-flop to WIDTH × NREGS storage with write-port arbitration, a "no register" ID, and an optional write-through bypass mode.

## Interface
- WIDTH, 64, bits per register
- NREGS, 15, number of implemented registers (IDs 0..NREGS-1)
- ADDR_W, 4, register-ID width
- NONE_ID, 4'hF, ID meaning "no register"; never read or written
- BYPASS, 0, 1 = same-cycle write data forwarded to read ports

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all registers
- en  in  1  global write enable (0 = stall, no writes)
- srcA  in  ADDR_W  read port A register ID
- srcB  in  ADDR_W  read port B register ID
- valA  out  WIDTH  read data A
- valB  out  WIDTH  read data B
- dstE  in  ADDR_W  write port E register ID
- valE  in  WIDTH  write port E data
- dstM  in  ADDR_W  write port M register ID
- valM  in  WIDTH  write port M data

## Operation
- Storage: NREGS words, each WIDTH bits; no other state.
- Reset: at a rising edge with reset=1, every word ← 0; all writes that cycle ignored regardless of en.
- Write (reset=0, en=1): at rising edge, regs[dstE] ← valE if dstE valid; regs[dstM] ← valM if dstM valid.
- Valid ID: ID < NREGS and ID != NONE_ID. Invalid IDs (NONE_ID or ≥ NREGS) never write.
- Collision: dstE == dstM, both valid → valM written, valE dropped (popq %rsp semantics).
- en=0, reset=0: all words hold.
- Read: valA = regs[srcA] if srcA valid, else 0; same for valB/srcB. Purely combinational from state.
- BYPASS=1: if reset=0, en=1 and srcX equals a valid dstM, valX = valM; else if equal to a valid dstE, valX = valE; else stored value. Port M takes priority, matching the write collision rule. Bypass inactive when reset=1 or en=0.
- BYPASS=0: read ports never see same-cycle write data.

## Timing
- Write latency: 1 cycle; data presented with dstE/dstM visible on valA/valB after the next rising edge (BYPASS=0), or combinationally in the same cycle (BYPASS=1).
- Read latency: 0 cycles (combinational from srcA/srcB and state).
- Reset values: all words 0, so valA = valB = 0 for every srcA/srcB from the cycle after the reset edge until the first write.
- Reset is effective only on a clock edge; asserting reset between edges does not change state or outputs (BYPASS=0).
- Reset asserted mid-stream: writes presented in the reset cycle are lost; first write accepted on the first edge with reset=0 and en=1.
- Both read ports may address the same register, and may match a write ID, in any cycle; no structural hazard.

## Test plan
- Reset: write 0xDEAD_BEEF to regs 0..14, assert reset one edge → all srcA/srcB reads return 0; srcA=4'hF returns 0.
- Dual write: dstE=3/valE=0x11, dstM=7/valM=0x22, en=1, one edge → srcA=3 gives 0x11, srcB=7 gives 0x22; no other register changes.
- Collision: dstE=dstM=4, valE=0xAAAA, valM=0x5555, one edge → reg 4 = 0x5555.
- Stall and NONE: en=0 with dstE=2/valE=0x99 → reg 2 unchanged; en=1 with dstE=4'hF/valE=0x77 → no register changes, srcA=4'hF returns 0.
- Bypass (BYPASS=1): reg 5 = 0x1, same cycle dstE=5/valE=0x2, srcA=5 → valA=0x2 before the edge. With dstM=5/valM=0x3 also set → valA=0x3. With en=0 → valA=0x1.
- Reset vs write: reset=1, en=1, dstE=1/valE=0xFF for one edge → reg 1 = 0. Next edge with reset=0 and the same write → reg 1 = 0xFF.
